icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Refill controller sitting between the fetch unit, the instruction cache and IRAM. On an instruction-cache miss it stalls fetch, fetches the whole aligned block from IRAM as a burst of narrow beats, and assembles it into a cache line. It then writes the line into the cache with a one-cycle write strobe, during which the cache forwards the missing instruction to fetch. It also steers the cache's PC input so the line is always tagged with the missing address, even if fetch is redirected mid-refill.

## Interface
- PC_SIZE, 32, width of PC and IRAM byte address
- BLOCK_SIZE, 128, cache line width in bits; power of two, multiple of MEM_WIDTH
- MEM_WIDTH, 32, IRAM read data width; BEATS = BLOCK_SIZE/MEM_WIDTH ≥ 2
- Reset nrst is synchronous and active-low; the clock is clk.

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- fetch_req  in  1  fetch unit wants an instruction at pc this cycle
- pc  in  PC_SIZE  fetch PC
- flush  in  1  fetch redirect (branch/exception); current fetch is void
- hit  in  1  cache hit for icache_pc
- icache_pc  out  PC_SIZE  PC driven to the cache
- icache_we  out  1  cache line write strobe
- block_out  out  [0:BLOCK_SIZE-1]  assembled line to the cache
- stall  out  1  fetch must hold pc and ignore the fetched instruction
- mem_req  out  1  IRAM burst request
- mem_addr  out  PC_SIZE  block-aligned burst byte address
- mem_gnt  in  1  IRAM accepted the request
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  MEM_WIDTH  read beat
- miss_cnt  out  16  saturating count of refills started

## Operation
- FSM states: IDLE, REQ, BURST, FILL.
- **IDLE**
  - icache_pc = pc.
  - If fetch_req & ~hit & ~flush:
    - latch miss_pc = pc;
    - set mem_addr = pc with low log2(BLOCK_SIZE/8) bits cleared;
    - clear beat counter and the discard flag;
    - increment miss_cnt, saturating at 0xFFFF;
    - go to REQ.
  - flush has priority over a miss in the same cycle.
- **REQ**
  - mem_req = 1; mem_addr is held stable.
  - When mem_gnt = 1, go to BURST; mem_req drops the following cycle.
- **BURST**
  - Each cycle with mem_rvalid = 1, write beat k to block_out[k·MEM_WIDTH : k·MEM_WIDTH+MEM_WIDTH-1], with mem_rdata MSB at the lowest index, then k++.
  - After beat BEATS-1, go to FILL.
  - Gaps in mem_rvalid are allowed.
- **FILL**
  - icache_we = 1 for exactly this cycle, then go to IDLE.
- **icache_pc**: in REQ, BURST and FILL, icache_pc = miss_pc.
- **flush**: flush in REQ, BURST or FILL sets discard. The burst always completes and the line is still written, because the IRAM handshake cannot be aborted.
- **stall**
  - IDLE: stall = fetch_req & ~hit & ~flush.
  - REQ and BURST: stall = 1.
  - FILL: stall = discard | flush.
- mem_rvalid is ignored outside BURST; no data beat may be counted in the cycle mem_gnt is accepted.
- Reset values: state IDLE, mem_req 0, mem_addr 0, icache_we 0, block_out all 0, discard 0, beat counter 0, miss_cnt 0.
- Reset mid-burst returns to IDLE immediately. Any IRAM beats still arriving are ignored, and no cache write occurs.

## Timing
- Miss detected at cycle 0 → mem_req = 1 from cycle 1.
- Grant at cycle g → beats from cycle g+1 at the earliest.
- Last beat at cycle L → FILL (icache_we = 1) at L+1 → IDLE at L+2, where the re-presented pc hits.
- Minimum penalty (g = 1, BEATS = 4, no gaps): stall high in cycles 0–5, FILL at cycle 6, forwarded instruction consumed at cycle 6.
- All outputs except icache_pc and stall are registered; icache_pc and stall are combinational from state, pc, hit, fetch_req and flush.

## Test plan
- **Basic miss:** pc = 0x104, miss, gnt at cycle 1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 in cycles 2–5 → mem_addr = 0x100; block_out = 0x11111111_22222222_33333333_44444444; icache_we only at cycle 6 with icache_pc = 0x104; stall low at cycle 6; miss_cnt = 1.
- **Hit:** fetch_req with hit = 1 in IDLE → stall 0, mem_req never asserted, miss_cnt unchanged.
- **Delayed handshake:** gnt after 5 REQ cycles, rvalid with 2-cycle gaps → mem_req and mem_addr stable until gnt; exactly 4 beats captured in order; a single FILL cycle.
- **Flush in BURST:** pc changes to 0x200 at beat 2 → icache_pc stays 0x104 through FILL; line written; stall = 1 in FILL; next IDLE evaluates 0x200.
- **Reset mid-burst:** nrst low after beat 1, then 2 further rvalid beats → IDLE, block_out = 0, no icache_we, mem_req = 0, miss_cnt = 0.
- **Simultaneous events:** miss together with flush in IDLE → no refill; then back-to-back misses at 0x000 and 0x010 → two full refills, miss_cnt = 2.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of fetch, cache and IRAM signals around the instruction-cache refill controller.
interface icache_refill_ctrl_if #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned MEM_WIDTH  = 32
);

  // Fetch side
  logic                  fetch_req;
  logic [PC_SIZE-1:0]    pc;
  logic                  flush;
  logic                  stall;

  // Cache side
  logic                  hit;
  logic [PC_SIZE-1:0]    icache_pc;
  logic                  icache_we;
  logic [0:BLOCK_SIZE-1] block_out;

  // IRAM side
  logic                  mem_req;
  logic [PC_SIZE-1:0]    mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [MEM_WIDTH-1:0]  mem_rdata;

  // Statistics
  logic [15:0]           miss_cnt;

  // Refill controller view
  modport slave (
    input  fetch_req, pc, flush, hit, mem_gnt, mem_rvalid, mem_rdata,
    output icache_pc, icache_we, block_out, stall, mem_req, mem_addr, miss_cnt
  );

  // Environment view (fetch unit, cache and IRAM together)
  modport master (
    output fetch_req, pc, flush, hit, mem_gnt, mem_rvalid, mem_rdata,
    input  icache_pc, icache_we, block_out, stall, mem_req, mem_addr, miss_cnt
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: on a miss, bursts the aligned block from
// IRAM, assembles the line, writes it to the cache for one cycle and keeps the
// cache PC pinned to the missing address until the write is done.
module icache_refill_ctrl #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned MEM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  icache_refill_ctrl_if.slave   bus
);

  localparam int unsigned BEATS  = BLOCK_SIZE / MEM_WIDTH;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(BLOCK_SIZE / 8);
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2,
    S_FILL  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [PC_SIZE-1:0]    r_miss_pc;
  logic [PC_SIZE-1:0]    r_mem_addr;
  logic                  r_mem_req;
  logic                  r_icache_we;
  logic [0:BLOCK_SIZE-1] r_block;
  logic                  r_discard;
  logic [BEAT_W-1:0]     r_beat;
  logic [CNT_W-1:0]      r_miss_cnt;

  logic                  w_miss;
  logic                  w_last_beat;
  logic [PC_SIZE-1:0]    w_aligned_pc;
  logic [PC_SIZE-1:0]    w_icache_pc;
  logic                  w_stall;

  // A miss only starts a refill from IDLE; a same-cycle redirect voids it.
  assign w_miss       = (r_state == S_IDLE) & bus.fetch_req & ~bus.hit & ~bus.flush;
  assign w_last_beat  = bus.mem_rvalid & (r_beat == BEAT_W'(BEATS - 1));
  assign w_aligned_pc = {bus.pc[PC_SIZE-1:OFF_W], {OFF_W{1'b0}}};

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_miss)      w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_gnt) w_state_nxt = S_BURST;
      S_BURST: if (w_last_beat) w_state_nxt = S_FILL;
      S_FILL:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs: cache PC steering and fetch stall
  always_comb begin
    w_icache_pc = r_miss_pc;
    w_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_icache_pc = bus.pc;
        w_stall     = w_miss;
      end
      S_REQ, S_BURST: w_stall = 1'b1;
      S_FILL:         w_stall = r_discard | bus.flush;
      default:        w_stall = 1'b0;
    endcase
  end

  // Registered outputs and refill datapath (miss capture, beat assembly, discard)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_miss_pc   <= '0;
      r_mem_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_icache_we <= 1'b0;
      r_block     <= '0;
      r_discard   <= 1'b0;
      r_beat      <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_mem_req   <= (w_state_nxt == S_REQ);
      r_icache_we <= (w_state_nxt == S_FILL);

      if (w_miss) begin
        r_miss_pc  <= bus.pc;
        r_mem_addr <= w_aligned_pc;
        r_beat     <= '0;
        r_discard  <= 1'b0;
        if (r_miss_cnt != {CNT_W{1'b1}}) begin
          r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
      end

      // The IRAM burst cannot be cancelled, so a redirect only marks the result void.
      if ((r_state != S_IDLE) && bus.flush) begin
        r_discard <= 1'b1;
      end

      if ((r_state == S_BURST) && bus.mem_rvalid) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (r_beat == BEAT_W'(k)) begin
            r_block[k*MEM_WIDTH +: MEM_WIDTH] <= bus.mem_rdata;
          end
        end
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  assign bus.icache_pc = w_icache_pc;
  assign bus.stall     = w_stall;
  assign bus.icache_we = r_icache_we;
  assign bus.block_out = r_block;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a per-cycle vector table for the basic
// miss plus hand-written sequences for handshake, flush, reset and back-to-back cases.
module tb_icache_refill_ctrl;

  localparam int unsigned PC_SIZE    = 32;
  localparam int unsigned BLOCK_SIZE = 128;
  localparam int unsigned MEM_WIDTH  = 32;
  localparam int unsigned NVEC       = 8;

  logic clk;
  logic nrst;

  int n_tests;
  int n_fail;

  icache_refill_ctrl_if #(
    .PC_SIZE(PC_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .MEM_WIDTH(MEM_WIDTH)
  ) bus ();

  icache_refill_ctrl #(
    .PC_SIZE(PC_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .MEM_WIDTH(MEM_WIDTH)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fetch_req;
    logic [31:0] pc;
    logic        flush;
    logic        hit;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_stall;
    logic [31:0] e_icache_pc;
    logic        e_mem_req;
    logic [31:0] e_mem_addr;
    logic        e_we;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic fr, input logic [31:0] p, input logic fl, input logic h,
                       input logic g, input logic rv, input logic [31:0] d);
    @(negedge clk);
    bus.fetch_req  = fr;
    bus.pc         = p;
    bus.flush      = fl;
    bus.hit        = h;
    bus.mem_gnt    = g;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = d;
    #1;
  endtask

  // Full minimum-latency refill of one block, ending with the FILL cycle.
  task automatic refill(input logic [31:0] p, input logic [31:0] base, input string tag);
    drive(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check({tag, " miss stall"}, 128'(bus.stall), 128'(1'b1));
    drive(1'b1, p, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check({tag, " req"}, 128'(bus.mem_req), 128'(1'b1));
    check({tag, " addr"}, 128'(bus.mem_addr), 128'(p & 32'hFFFF_FFF0));
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b1, base ^ 32'(k));
    end
    drive(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check({tag, " fill we"}, 128'(bus.icache_we), 128'(1'b1));
    check({tag, " fill pc"}, 128'(bus.icache_pc), 128'(p));
    check({tag, " fill stall"}, 128'(bus.stall), 128'(1'b0));
    check({tag, " line"}, 128'(bus.block_out), {base, base ^ 32'd1, base ^ 32'd2, base ^ 32'd3});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            fr    pc           fl    hit   gnt   rv    rdata          stall ipc          mreq  maddr        we
    tbl[0] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104, 1'b0, 32'h000, 1'b0};
    tbl[1] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
    tbl[2] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h104, 1'b0, 32'h100, 1'b0};
    tbl[3] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 32'h104, 1'b0, 32'h100, 1'b0};
    tbl[4] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 32'h104, 1'b0, 32'h100, 1'b0};
    tbl[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b1, 32'h104, 1'b0, 32'h100, 1'b0};
    tbl[6] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h104, 1'b0, 32'h100, 1'b1};
    tbl[7] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h104, 1'b0, 32'h100, 1'b0};

    // Reset
    nrst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst mem_req", 128'(bus.mem_req), 128'(1'b0));
    check("rst mem_addr", 128'(bus.mem_addr), 128'(32'h0));
    check("rst we", 128'(bus.icache_we), 128'(1'b0));
    check("rst block", 128'(bus.block_out), 128'(0));
    check("rst miss_cnt", 128'(bus.miss_cnt), 128'(16'h0));
    check("rst stall", 128'(bus.stall), 128'(1'b0));
    nrst = 1'b1;

    // Basic miss, one table row per cycle
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].fetch_req, tbl[i].pc, tbl[i].flush, tbl[i].hit,
            tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
      check($sformatf("basic[%0d] stall", i), 128'(bus.stall), 128'(tbl[i].e_stall));
      check($sformatf("basic[%0d] icache_pc", i), 128'(bus.icache_pc), 128'(tbl[i].e_icache_pc));
      check($sformatf("basic[%0d] mem_req", i), 128'(bus.mem_req), 128'(tbl[i].e_mem_req));
      check($sformatf("basic[%0d] mem_addr", i), 128'(bus.mem_addr), 128'(tbl[i].e_mem_addr));
      check($sformatf("basic[%0d] we", i), 128'(bus.icache_we), 128'(tbl[i].e_we));
    end
    check("basic line", 128'(bus.block_out),
          {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    check("basic miss_cnt", 128'(bus.miss_cnt), 128'(16'd1));

    // Hit in IDLE
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check($sformatf("hit[%0d] stall", i), 128'(bus.stall), 128'(1'b0));
      check($sformatf("hit[%0d] icache_pc", i), 128'(bus.icache_pc), 128'(32'h300 + 32'(4 * i)));
      check($sformatf("hit[%0d] mem_req", i), 128'(bus.mem_req), 128'(1'b0));
    end
    check("hit miss_cnt", 128'(bus.miss_cnt), 128'(16'd1));

    // Delayed grant and gapped beats; stray rvalid in REQ and at grant is ignored
    drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("dly miss stall", 128'(bus.stall), 128'(1'b1));
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD00000 + 32'(i));
      check($sformatf("dly req[%0d]", i), 128'(bus.mem_req), 128'(1'b1));
      check($sformatf("dly addr[%0d]", i), 128'(bus.mem_addr), 128'(32'h2A0));
      check($sformatf("dly stall[%0d]", i), 128'(bus.stall), 128'(1'b1));
    end
    drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD0FFFF);
    check("dly req at gnt", 128'(bus.mem_req), 128'(1'b1));
    begin
      logic [31:0] dv [4];
      dv[0] = 32'hA0A0A0A0; dv[1] = 32'hB1B1B1B1; dv[2] = 32'hC2C2C2C2; dv[3] = 32'hD3D3D3D3;
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b0, 1'b1, dv[k]);
        check($sformatf("dly beat[%0d] req", k), 128'(bus.mem_req), 128'(1'b0));
        check($sformatf("dly beat[%0d] we", k), 128'(bus.icache_we), 128'(1'b0));
        if (k < 3) begin
          for (int g = 0; g < 2; g++) begin
            drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
            check($sformatf("dly gap[%0d.%0d] we", k, g), 128'(bus.icache_we), 128'(1'b0));
            check($sformatf("dly gap[%0d.%0d] stall", k, g), 128'(bus.stall), 128'(1'b1));
          end
        end
      end
    end
    drive(1'b1, 32'h2A8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99999999);
    check("dly fill we", 128'(bus.icache_we), 128'(1'b1));
    check("dly fill stall", 128'(bus.stall), 128'(1'b0));
    check("dly fill pc", 128'(bus.icache_pc), 128'(32'h2A8));
    drive(1'b1, 32'h2A8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h88888888);
    check("dly single fill", 128'(bus.icache_we), 128'(1'b0));
    check("dly line", 128'(bus.block_out),
          {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3});
    check("dly miss_cnt", 128'(bus.miss_cnt), 128'(16'd2));

    // Flush during BURST: cache PC stays on the miss, line still written, fetch stalled in FILL
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01010101);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h02020202);
    drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h03030303);
    check("fl beat2 pc", 128'(bus.icache_pc), 128'(32'h104));
    check("fl beat2 stall", 128'(bus.stall), 128'(1'b1));
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04040404);
    check("fl beat3 pc", 128'(bus.icache_pc), 128'(32'h104));
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("fl fill we", 128'(bus.icache_we), 128'(1'b1));
    check("fl fill pc", 128'(bus.icache_pc), 128'(32'h104));
    check("fl fill stall", 128'(bus.stall), 128'(1'b1));
    check("fl line", 128'(bus.block_out),
          {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404});
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("fl idle pc", 128'(bus.icache_pc), 128'(32'h200));
    check("fl idle stall", 128'(bus.stall), 128'(1'b1));
    check("fl idle we", 128'(bus.icache_we), 128'(1'b0));

    // Refill of 0x200 interrupted by reset after beat 1
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rm req", 128'(bus.mem_req), 128'(1'b1));
    check("rm addr", 128'(bus.mem_addr), 128'(32'h200));
    check("rm miss_cnt", 128'(bus.miss_cnt), 128'(16'd4));
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A0A0A0A);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0B0B0B0B);
    nrst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0C0C0C0C);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, (i < 2) ? 1'b1 : 1'b0, 32'h0D0D0D0D + 32'(i));
      check($sformatf("rm[%0d] we", i), 128'(bus.icache_we), 128'(1'b0));
      check($sformatf("rm[%0d] req", i), 128'(bus.mem_req), 128'(1'b0));
      check($sformatf("rm[%0d] block", i), 128'(bus.block_out), 128'(0));
      check($sformatf("rm[%0d] stall", i), 128'(bus.stall), 128'(1'b0));
    end
    check("rm miss_cnt", 128'(bus.miss_cnt), 128'(16'd0));

    // Miss with simultaneous flush is voided
    drive(1'b1, 32'h040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("sim stall", 128'(bus.stall), 128'(1'b0));
    check("sim pc", 128'(bus.icache_pc), 128'(32'h040));
    drive(1'b0, 32'h040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("sim no req", 128'(bus.mem_req), 128'(1'b0));
    check("sim miss_cnt", 128'(bus.miss_cnt), 128'(16'd0));

    // Back-to-back refills
    refill(32'h000, 32'h5A5A0000, "b2b0");
    refill(32'h010, 32'h3C3C1000, "b2b1");
    drive(1'b1, 32'h010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("b2b idle we", 128'(bus.icache_we), 128'(1'b0));
    check("b2b idle stall", 128'(bus.stall), 128'(1'b0));
    check("b2b miss_cnt", 128'(bus.miss_cnt), 128'(16'd2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
